// File: rtl/axi_lsu_master.sv
// Single-outstanding AXI-lite initiator: turns one LSU load/store into AW/W/B or AR/R traffic.
// Optional watchdog and rlast check are built only when AXI_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module axi_lsu_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t state, state_n;
  logic                req_ready_n, rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0]   rsp_rdata_n, wdata_n;
  logic                awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_W-1:0]   awaddr_n, araddr_n;
  logic [DATA_W/8-1:0] wstrb_n;

  assign fsm_state = state;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;
  logic             rd_err_n;
  assign rd_err_n = (rresp != 2'b00) || !rlast;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic rd_err_n;
  logic unused_rlast;
  assign rd_err_n     = (rresp != 2'b00);
  assign unused_rlast = rlast;
`endif

  // Handshake rule on every channel: a transfer happens on the edge where valid and ready are
  // both high; a valid, once raised, holds its payload stable until that edge and drops after it.
  always_comb begin
    state_n     = state;
    req_ready_n = req_ready;
    rsp_valid_n = 1'b0;
    rsp_err_n   = rsp_err;
    rsp_rdata_n = rsp_rdata;
    awvalid_n   = awvalid;
    awaddr_n    = awaddr;
    wvalid_n    = wvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    bready_n    = bready;
    arvalid_n   = arvalid;
    araddr_n    = araddr;
    rready_n    = rready;
    case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid) begin
          req_ready_n = 1'b0;
          if (req_we) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = req_addr;
            wdata_n   = req_wdata;
            wstrb_n   = req_wstrb;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            araddr_n  = req_addr;
            state_n   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; move on once neither is still pending.
        if (awvalid && awready) awvalid_n = 1'b0;
        if (wvalid && wready)   wvalid_n  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid && bready) begin
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = '0;
          rsp_err_n   = (bresp != 2'b00);
          req_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rvalid && rready) begin
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = rdata;
          rsp_err_n   = rd_err_n;
          req_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef AXI_TIMEOUT_EN
    // Watchdog only fires when the current state is not already completing this cycle.
    if (state != IDLE && state_n == state && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      awvalid_n   = 1'b0;
      wvalid_n    = 1'b0;
      bready_n    = 1'b0;
      arvalid_n   = 1'b0;
      rready_n    = 1'b0;
      rsp_valid_n = 1'b1;
      rsp_err_n   = 1'b1;
      rsp_rdata_n = '0;
      req_ready_n = 1'b1;
      state_n     = IDLE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= req_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      awvalid   <= awvalid_n;
      awaddr    <= awaddr_n;
      wvalid    <= wvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      bready    <= bready_n;
      arvalid   <= arvalid_n;
      araddr    <= araddr_n;
      rready    <= rready_n;
    end
  end

`ifdef AXI_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset || state_n != state) cnt <= '0;
    else if (state != IDLE)         cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_axi_lsu_master.sv
// Directed bench for axi_lsu_master: a vector table of single transactions against a small
// slave model, plus hand sequences for reset mid-transaction and (with AXI_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_axi_lsu_master;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [2:0]  fsm_state;

  axi_lsu_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // aw_at/w_at/ar_at: slave ready is high in every cycle after edge N (edge 0 accepts the request)
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        rlast;
    int          aw_at;
    int          w_at;
    int          ar_at;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0; rlast = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " awvalid"}, {31'b0, awvalid}, 0);
    chk({tag, " wvalid"},  {31'b0, wvalid},  0);
    chk({tag, " bready"},  {31'b0, bready},  0);
    chk({tag, " arvalid"}, {31'b0, arvalid}, 0);
    chk({tag, " rready"},  {31'b0, rready},  0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_n, rsp_c;
    logic b_pend, r_pend, bready_prev, rready_prev, got_err;
    logic [31:0] got_rdata;
    c = -1; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rsp_n = 0; rsp_c = -1;
    b_pend = 0; r_pend = 0; bready_prev = 0; rready_prev = 0; got_err = 0; got_rdata = '0;
    chk({tag, " req_ready before"}, {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    while (rsp_n == 0 && c < 40) begin
      @(posedge clock); #1; c++;
      req_valid = 1'b0;
      if (b_pend) bvalid = 1'b0;
      if (r_pend) rvalid = 1'b0;
      if (rsp_valid) begin
        rsp_n++; rsp_c = c; got_rdata = rsp_rdata; got_err = rsp_err;
        chk({tag, " req_ready with rsp"}, {31'b0, req_ready}, 1);
      end
      awready = (c >= v.aw_at);
      wready  = (c >= v.w_at);
      arready = (c >= v.ar_at);
      // slave answers one cycle after it first sees the response-channel ready
      if (!bvalid && bready && bready_prev) begin bvalid = 1'b1; bresp = v.resp; end
      if (!rvalid && rready && rready_prev) begin
        rvalid = 1'b1; rresp = v.resp; rdata = v.rdata; rlast = v.rlast;
      end
      bready_prev = bready; rready_prev = rready;
      b_pend = bvalid && bready;
      r_pend = rvalid && rready;
      if (b_pend) b_hs++;
      if (r_pend) r_hs++;
      if (awvalid && awready) begin aw_hs++; chk({tag, " awaddr"}, awaddr, v.addr); end
      if (wvalid) begin
        chk({tag, " wdata"}, wdata, v.wdata);
        chk({tag, " wstrb"}, {28'b0, wstrb}, {28'b0, v.wstrb});
      end
      if (wvalid && wready) w_hs++;
      if (arvalid && arready) begin ar_hs++; chk({tag, " araddr"}, araddr, v.addr); end
    end
    chk({tag, " rsp count"}, rsp_n, 1);
    chk({tag, " latency"}, rsp_c, v.exp_lat);
    chk({tag, " rsp_rdata"}, got_rdata, v.exp_rdata);
    chk({tag, " rsp_err"}, {31'b0, got_err}, {31'b0, v.exp_err});
    chk({tag, " aw handshakes"}, aw_hs, v.we ? 1 : 0);
    chk({tag, " w handshakes"},  w_hs,  v.we ? 1 : 0);
    chk({tag, " b handshakes"},  b_hs,  v.we ? 1 : 0);
    chk({tag, " ar handshakes"}, ar_hs, v.we ? 0 : 1);
    chk({tag, " r handshakes"},  r_hs,  v.we ? 0 : 1);
    idle_inputs();
    @(posedge clock); #1;
    chk({tag, " rsp one cycle"}, {31'b0, rsp_valid}, 0);
    check_quiet({tag, " after"});
  endtask

  // ---------------- test ----------------
  initial begin
    //          we    addr          wdata         strb  rdata         resp  rl aw w  ar exp_rdata     err lat
    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        2'b00, 1, 0, 0, 0, 32'h0,        0, 3};
    vecs[1] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 1, 0, 0, 0, 32'hDEAD_BEEF, 0, 3};
    vecs[2] = '{1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'h3, 32'h0,        2'b00, 1, 1, 4, 0, 32'h0,        0, 7};
    vecs[3] = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'h1234_5678, 2'b10, 1, 0, 0, 0, 32'h1234_5678, 1, 3};
    vecs[4] = '{1'b1, 32'h1000_0008, 32'h0BAD_F00D, 4'hC, 32'h0,        2'b11, 1, 0, 0, 0, 32'h0,        1, 3};
    vecs[5] = '{1'b0, 32'h2000_0100, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b00, 1, 0, 0, 2, 32'hA5A5_5A5A, 0, 5};
    vecs[6] = '{1'b1, 32'h2000_0200, 32'h1357_9BDF, 4'h9, 32'h0,        2'b00, 1, 3, 0, 0, 32'h0,        0, 6};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset req_ready", {31'b0, req_ready}, 1);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset rsp_err",   {31'b0, rsp_err},   0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset awaddr",    awaddr, 0);
    chk("reset araddr",    araddr, 0);
    chk("reset wdata",     wdata, 0);
    chk("reset wstrb",     {28'b0, wstrb}, 0);
    chk("reset fsm_state", {29'b0, fsm_state}, 0);
    check_quiet("reset");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // store stalled in WR_RESP, extra request held, then reset discards the transaction
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3000_0000; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rst seq bready", {31'b0, bready}, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("busy req_ready", {31'b0, req_ready}, 0);
      chk("busy arvalid",   {31'b0, arvalid},   0);
      chk("busy rsp_valid", {31'b0, rsp_valid}, 0);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_quiet("mid reset");
    chk("mid reset req_ready", {31'b0, req_ready}, 1);
    chk("mid reset rsp_valid", {31'b0, rsp_valid}, 0);
    chk("mid reset fsm_state", {29'b0, fsm_state}, 0);
    idle_inputs();
    bvalid = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("stray resp rsp_valid", {31'b0, rsp_valid}, 0);
    end
    idle_inputs();
    @(posedge clock); #1;
    run_vec(vecs[1], "post reset load");

`ifdef AXI_TIMEOUT_EN
    begin
      int c;
      vec_t v;
      c = -1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h5000_0000;
      while (c < 40) begin
        @(posedge clock); #1; c++;
        req_valid = 1'b0;
        if (rsp_valid) break;
      end
      chk("timeout latency",   c, 16);
      chk("timeout rsp_err",   {31'b0, rsp_err}, 1);
      chk("timeout rsp_rdata", rsp_rdata, 0);
      chk("timeout req_ready", {31'b0, req_ready}, 1);
      check_quiet("timeout");
      @(posedge clock); #1;
      chk("timeout arvalid after", {31'b0, arvalid}, 0);
      v = vecs[1];
      v.rlast = 1'b0;
      v.exp_err = 1'b1;
      run_vec(v, "rlast low");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
